// File: rtl/selective_amp_bank_if.sv
// Sample, coefficient and result signals of the selective amplifier bank.
// The master drives samples and coefficients; the slave is the filter bank itself.
interface selective_amp_bank_if #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 18,
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_data;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_ch;
    logic [1:0]               cfg_sel;
    logic signed [COEF_W-1:0] cfg_data;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic [DATA_W-2:0]        out_peak;

    modport master (
        output in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  in_ready, out_valid, out_ch, out_data, out_peak
    );

    modport slave (
        input  in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output in_ready, out_valid, out_ch, out_data, out_peak
    );
endinterface

// File: rtl/selective_amp_bank.sv
// Time-multiplexed bank of second-order bandpass resonators with peak-envelope tracking.
// One shared multiplier; each accepted sample walks IDLE -> MB -> MA1 -> MA2 -> WB.
module selective_amp_bank #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 18,
    parameter int CHANNELS = 4,
    parameter int DECAY_SH = 4
) (
    input logic clk,
    input logic rst,
    selective_amp_bank_if.slave bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FRAC   = COEF_W - 2;
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int PK_W   = DATA_W - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MB   = 3'd1;
    localparam logic [2:0] S_MA1  = 3'd2;
    localparam logic [2:0] S_MA2  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Per-channel coefficients, filter state and envelope
    logic signed [COEF_W-1:0] b0_q [CHANNELS], b0_d [CHANNELS];
    logic signed [COEF_W-1:0] a1_q [CHANNELS], a1_d [CHANNELS];
    logic signed [COEF_W-1:0] a2_q [CHANNELS], a2_d [CHANNELS];
    logic signed [DATA_W-1:0] x1_q [CHANNELS], x1_d [CHANNELS];
    logic signed [DATA_W-1:0] x2_q [CHANNELS], x2_d [CHANNELS];
    logic signed [DATA_W-1:0] y1_q [CHANNELS], y1_d [CHANNELS];
    logic signed [DATA_W-1:0] y2_q [CHANNELS], y2_d [CHANNELS];
    logic [PK_W-1:0]          pk_q [CHANNELS], pk_d [CHANNELS];

    // Snapshot of the in-flight sample
    logic [2:0]               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     ch_ok_q, ch_ok_d;
    logic                     clr_pend_q, clr_pend_d;
    logic signed [DATA_W-1:0] cur_x_q, cur_x_d, cur_y1_q, cur_y1_d, cur_y2_q, cur_y2_d;
    logic signed [DATA_W:0]   cur_diff_q, cur_diff_d;
    logic signed [COEF_W-1:0] cur_b0_q, cur_b0_d, cur_a1_q, cur_a1_d, cur_a2_q, cur_a2_d;
    logic [PK_W-1:0]          cur_pk_q, cur_pk_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    logic                     out_valid_q, out_valid_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic [PK_W-1:0]          out_peak_q, out_peak_d;

    logic                     accept, in_ch_ok, cfg_clr, wb_en, in_range;
    logic [CH_W-1:0]          in_idx;
    logic signed [COEF_W-1:0] mul_c;
    logic signed [DATA_W:0]   mul_v;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, shifted;
    logic [ACC_W-DATA_W:0]    hi;
    logic signed [DATA_W-1:0] y_sat, y_mag;
    logic [PK_W-1:0]          y_abs, pk_dec, pk_new;

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_peak  = out_peak_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign in_ch_ok = int'(bus.in_ch) < CHANNELS;
    assign in_idx   = in_ch_ok ? bus.in_ch : '0;
    assign cfg_clr  = bus.cfg_we && (bus.cfg_sel == 2'd3);
    assign wb_en    = (state_q == S_WB) && ch_ok_q && !clr_pend_q;

    always_comb begin
        mul_c = '0;
        mul_v = '0;
        case (state_q)
            S_MB:    begin mul_c = cur_b0_q; mul_v = cur_diff_q; end
            S_MA1:   begin mul_c = cur_a1_q; mul_v = {cur_y1_q[DATA_W-1], cur_y1_q}; end
            S_MA2:   begin mul_c = cur_a2_q; mul_v = {cur_y2_q[DATA_W-1], cur_y2_q}; end
            default: begin mul_c = '0; mul_v = '0; end
        endcase
    end

    assign prod     = PROD_W'(mul_c) * PROD_W'(mul_v);
    assign prod_ext = ACC_W'(prod);

    // Floor shift, then saturate unless every bit above the sign agrees with it
    assign shifted  = acc_q >>> FRAC;
    assign hi       = shifted[ACC_W-1:DATA_W-1];
    assign in_range = (&hi) || (~|hi);
    assign y_sat    = in_range ? shifted[DATA_W-1:0] : (shifted[ACC_W-1] ? Y_MIN : Y_MAX);
    assign y_mag    = y_sat[DATA_W-1] ? -y_sat : y_sat;
    assign y_abs    = y_mag[DATA_W-1] ? '1 : y_mag[PK_W-1:0];
    assign pk_dec   = cur_pk_q - (cur_pk_q >> DECAY_SH);
    assign pk_new   = (y_abs > pk_dec) ? y_abs : pk_dec;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ch_ok_d     = ch_ok_q;
        clr_pend_d  = clr_pend_q | (cfg_clr && (bus.cfg_ch == ch_q));
        cur_x_d     = cur_x_q;
        cur_diff_d  = cur_diff_q;
        cur_y1_d    = cur_y1_q;
        cur_y2_d    = cur_y2_q;
        cur_b0_d    = cur_b0_q;
        cur_a1_d    = cur_a1_q;
        cur_a2_d    = cur_a2_q;
        cur_pk_d    = cur_pk_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_peak_d  = out_peak_q;
        case (state_q)
            S_IDLE: begin
                clr_pend_d = clr_pend_q;
                if (accept) begin
                    state_d    = S_MB;
                    ch_d       = bus.in_ch;
                    ch_ok_d    = in_ch_ok;
                    clr_pend_d = cfg_clr && (bus.cfg_ch == bus.in_ch);
                    cur_x_d    = bus.in_data;
                    cur_diff_d = (DATA_W+1)'(bus.in_data) - (DATA_W+1)'(x2_q[in_idx]);
                    cur_y1_d   = y1_q[in_idx];
                    cur_y2_d   = y2_q[in_idx];
                    cur_b0_d   = b0_q[in_idx];
                    cur_a1_d   = a1_q[in_idx];
                    cur_a2_d   = a2_q[in_idx];
                    cur_pk_d   = pk_q[in_idx];
                end
            end
            S_MB:  begin acc_d = prod_ext;         state_d = S_MA1; end
            S_MA1: begin acc_d = acc_q - prod_ext; state_d = S_MA2; end
            S_MA2: begin acc_d = acc_q - prod_ext; state_d = S_WB;  end
            S_WB: begin
                state_d = S_IDLE;
                if (ch_ok_q) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = ch_q;
                    out_data_d  = y_sat;
                    out_peak_d  = pk_new;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-back first, cfg second, so a clear always overrides the update
    always_comb begin
        b0_d = b0_q; a1_d = a1_q; a2_d = a2_q;
        x1_d = x1_q; x2_d = x2_q; y1_d = y1_q; y2_d = y2_q; pk_d = pk_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wb_en && (ch_q == CH_W'(i))) begin
                x2_d[i] = x1_q[i];
                x1_d[i] = cur_x_q;
                y2_d[i] = y1_q[i];
                y1_d[i] = y_sat;
                pk_d[i] = pk_new;
            end
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
                case (bus.cfg_sel)
                    2'd0: b0_d[i] = bus.cfg_data;
                    2'd1: a1_d[i] = bus.cfg_data;
                    2'd2: a2_d[i] = bus.cfg_data;
                    default: begin
                        x1_d[i] = '0; x2_d[i] = '0; y1_d[i] = '0; y2_d[i] = '0; pk_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;    ch_q <= '0;     ch_ok_q <= 1'b0;  clr_pend_q <= 1'b0;
            cur_x_q <= '0;        cur_diff_q <= '0; cur_y1_q <= '0; cur_y2_q <= '0;
            cur_b0_q <= '0;       cur_a1_q <= '0; cur_a2_q <= '0;   cur_pk_q <= '0;
            acc_q <= '0;          out_valid_q <= 1'b0; out_ch_q <= '0;
            out_data_q <= '0;     out_peak_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                b0_q[i] <= '0; a1_q[i] <= '0; a2_q[i] <= '0;
                x1_q[i] <= '0; x2_q[i] <= '0; y1_q[i] <= '0; y2_q[i] <= '0; pk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;   ch_q <= ch_d;   ch_ok_q <= ch_ok_d; clr_pend_q <= clr_pend_d;
            cur_x_q <= cur_x_d;   cur_diff_q <= cur_diff_d; cur_y1_q <= cur_y1_d; cur_y2_q <= cur_y2_d;
            cur_b0_q <= cur_b0_d; cur_a1_q <= cur_a1_d; cur_a2_q <= cur_a2_d; cur_pk_q <= cur_pk_d;
            acc_q <= acc_d;       out_valid_q <= out_valid_d; out_ch_q <= out_ch_d;
            out_data_q <= out_data_d; out_peak_q <= out_peak_d;
            b0_q <= b0_d; a1_q <= a1_d; a2_q <= a2_d;
            x1_q <= x1_d; x2_q <= x2_d; y1_q <= y1_d; y2_q <= y2_d; pk_q <= pk_d;
        end
    end
endmodule

// File: tb/tb_selective_amp_bank.sv
// Scoreboard bench for selective_amp_bank: a difference-equation model predicts each result
// when a sample is accepted; a monitor compares whenever out_valid is seen.
module tb_selective_amp_bank;
    localparam int DATA_W   = 16;
    localparam int COEF_W   = 18;
    localparam int CHANNELS = 3;   // leaves in_ch=3 representable but out of range
    localparam int DECAY_SH = 4;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FRAC     = COEF_W - 2;
    localparam longint YMAX = (64'sd1 <<< (DATA_W-1)) - 1;
    localparam longint YMIN = -(64'sd1 <<< (DATA_W-1));

    typedef struct {
        int     ch;
        longint data;
        longint peak;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    selective_amp_bank_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .CHANNELS(CHANNELS)) bus ();

    selective_amp_bank #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .CHANNELS(CHANNELS), .DECAY_SH(DECAY_SH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t   sb[$];
    int     cyc = 0;
    int     n_pass = 0;
    int     n_total = 0;
    int     last_acc = -1;
    longint m_b0[CHANNELS], m_a1[CHANNELS], m_a2[CHANNELS];
    longint m_x1[CHANNELS], m_x2[CHANNELS], m_y1[CHANNELS], m_y2[CHANNELS], m_pk[CHANNELS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            m_b0[i] = 0; m_a1[i] = 0; m_a2[i] = 0;
            m_x1[i] = 0; m_x2[i] = 0; m_y1[i] = 0; m_y2[i] = 0; m_pk[i] = 0;
        end
    endfunction

    // y = floor((b0*(x-x2) - a1*y1 - a2*y2) / 2^FRAC), clipped; envelope decays by p/2^DECAY_SH
    function automatic void model_sample(input int ch, input longint x, input int acc_cyc);
        longint acc, y, mag, dec, pk;
        exp_t   e;
        acc = m_b0[ch] * (x - m_x2[ch]) - m_a1[ch] * m_y1[ch] - m_a2[ch] * m_y2[ch];
        y   = acc >>> FRAC;
        if (y > YMAX) y = YMAX;
        if (y < YMIN) y = YMIN;
        mag = (y < 0) ? -y : y;
        if (mag > YMAX) mag = YMAX;
        dec = m_pk[ch] - (m_pk[ch] >> DECAY_SH);
        pk  = (mag > dec) ? mag : dec;
        m_x2[ch] = m_x1[ch]; m_x1[ch] = x;
        m_y2[ch] = m_y1[ch]; m_y1[ch] = y;
        m_pk[ch] = pk;
        e.ch = ch; e.data = y; e.peak = pk; e.cyc = acc_cyc;
        sb.push_back(e);
    endfunction

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic cfg(input int ch, input int sel, input longint val);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = CH_W'(ch);
        bus.cfg_sel  = 2'(sel);
        bus.cfg_data = COEF_W'(val);
        if (ch < CHANNELS) begin
            case (sel)
                0: m_b0[ch] = val;
                1: m_a1[ch] = val;
                2: m_a2[ch] = val;
                default: begin
                    m_x1[ch] = 0; m_x2[ch] = 0; m_y1[ch] = 0; m_y2[ch] = 0; m_pk[ch] = 0;
                end
            endcase
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge just after the accepting edge.
    task automatic send(input int ch, input longint x, input bit hold, input int gap);
        int waited = 0;
        int acc_cyc;
        bus.in_valid = 1'b1;
        bus.in_ch    = CH_W'(ch);
        bus.in_data  = DATA_W'(x);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        if (gap > 0) check("accept_spacing", acc_cyc - last_acc, gap);
        last_acc = acc_cyc;
        $display("send ch=%0d x=%0d accept_edge=%0d", ch, x, acc_cyc);
        if (ch < CHANNELS) model_sample(ch, x, acc_cyc);
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("result ch=%0d data=%0d peak=%0d (want %0d/%0d/%0d)",
                         bus.out_ch, bus.out_data, bus.out_peak, e.ch, e.data, e.peak);
                check("out_ch", longint'(bus.out_ch), e.ch);
                check("out_data", longint'(bus.out_data), e.data);
                check("out_peak", longint'(bus.out_peak), e.peak);
                check("latency", cyc - e.cyc, 4);
                check("in_ready_with_out", longint'(bus.in_ready), 1);
            end
        end
    end

    initial begin
        int imp[6] = '{1000, 0, 0, 0, 0, 0};
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_peak", longint'(bus.out_peak), 0);
        check("rst_out_ch", longint'(bus.out_ch), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", longint'(bus.in_ready), 1);

        // Differentiator on ch0, resonator on ch1, then ch0 continues from its own state
        cfg(0, 0, 32768);
        for (int i = 0; i < 4; i++) send(0, imp[i], 1'b0, 0);
        cfg(1, 0, 32768);
        cfg(1, 2, 32768);
        for (int i = 0; i < 6; i++) send(1, imp[i], 1'b0, 0);
        send(0, 0, 1'b0, 0);

        // Saturation both ways
        cfg(2, 0, 131071);
        send(2, 30000, 1'b0, 0);
        send(2, -30000, 1'b0, 0);

        // Back-to-back stream with in_valid held, including an out-of-range channel
        send(0, 123, 1'b1, 0);
        send(1, -77, 1'b1, 5);
        send(3, 999, 1'b1, 5);
        send(2, 5000, 1'b1, 5);
        send(0, -4000, 1'b0, 5);
        drain();

        // Coefficient rewrite at E+1 is not seen; clear at E+2 still produces an output
        send(0, 1000, 1'b0, 0);
        cfg(0, 0, 65536);
        send(0, 1000, 1'b0, 0);
        @(negedge clk);
        cfg(0, 3, 0);
        send(0, 1000, 1'b0, 0);
        send(0, 0, 1'b0, 0);
        drain();

        // Reset at E+2 aborts the sample and wipes everything
        send(1, 1000, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        model_reset();
        @(negedge clk);
        check("midrst_in_ready", longint'(bus.in_ready), 0);
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_out_data", longint'(bus.out_data), 0);
        check("midrst_out_peak", longint'(bus.out_peak), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        cfg(1, 0, 32768);
        cfg(1, 2, 32768);
        for (int i = 0; i < 3; i++) send(1, imp[i], 1'b0, 0);

        // Randomized samples, channels and coefficient writes
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    longint'($urandom_range(0, 262143)) - 131072);
            send(int'($urandom_range(0, 3)), longint'($urandom_range(0, 65535)) - 32768,
                 1'($urandom_range(0, 1)), 0);
        end
        bus.in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
